// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES arithmetic for the round datapath and the key expansion.
//   Contents:
//     SBOX_FWD / SBOX_INV : 256x8 substitution tables, flattened so that entry
//                           0 occupies the most significant byte.
//     sbox_fwd/sbox_inv   : table lookups.
//     xtime / gf_mul      : GF(2^8) arithmetic, reduction polynomial 0x11B.
//     mix_column(s)       : forward MixColumns on one column or a full state.
//     inv_mix_column(s)   : InvMixColumns on one column or a full state.
//     shift_rows / inv_shift_rows : pure byte permutations of the state.
//   State byte order: byte 0 at [127:120], column-major (bytes 0-3 = col 0).
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; all (Inv)MixColumns coefficients fit.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {gf_mul(b0, 4'h2) ^ gf_mul(b1, 4'h3) ^ b2 ^ b3,
            b0 ^ gf_mul(b1, 4'h2) ^ gf_mul(b2, 4'h3) ^ b3,
            b0 ^ b1 ^ gf_mul(b2, 4'h2) ^ gf_mul(b3, 4'h3),
            gf_mul(b0, 4'h3) ^ b1 ^ b2 ^ gf_mul(b3, 4'h2)};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {gf_mul(b0, 4'he) ^ gf_mul(b1, 4'hb) ^ gf_mul(b2, 4'hd) ^ gf_mul(b3, 4'h9),
            gf_mul(b0, 4'h9) ^ gf_mul(b1, 4'he) ^ gf_mul(b2, 4'hb) ^ gf_mul(b3, 4'hd),
            gf_mul(b0, 4'hd) ^ gf_mul(b1, 4'h9) ^ gf_mul(b2, 4'he) ^ gf_mul(b3, 4'hb),
            gf_mul(b0, 4'hb) ^ gf_mul(b1, 4'hd) ^ gf_mul(b2, 4'h9) ^ gf_mul(b3, 4'he)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  // Row r of column c takes the byte from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
    return r;
  endfunction

endpackage

// File: rtl/substitute4.sv
// ---------------------------------------------------------------------------
// substitute4
//   Four parallel S-boxes on one 32-bit word with one registered cycle of
//   latency. Byte i of out = S(byte i of in); forward S-box when enc_en=1,
//   inverse S-box otherwise. Shared with the key expansion, hence no reset.
//   Ports:
//     clk    : clock, rising edge
//     in     : 32-bit input word
//     out    : 32-bit substituted word, registered
//     enc_en : 1 = forward S-box, 0 = inverse S-box
// ---------------------------------------------------------------------------
module substitute4
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] in,
  output logic [31:0] out,
  input  logic        enc_en
);

  logic [31:0] sub_q;

  // NOTE: pure data register with no reset; whoever consumes it qualifies
  // its contents with a separately reset valid flag.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      sub_q[8*i +: 8] <= enc_en ? sbox_fwd(in[8*i +: 8]) : sbox_inv(in[8*i +: 8]);
  end

  assign out = sub_q;

endmodule

// File: rtl/encrypt_round.sv
// ---------------------------------------------------------------------------
// encrypt_round
//   One AES round (forward or inverse), two-stage pipeline, new input every
//   cycle, latency 2 clocks.
//     stage 1: (Inv)ShiftRows wiring + (Inv)SubBytes registered in four
//              substitute4 instances; key and control registered alongside.
//     stage 2: (Inv)MixColumns and key XOR, registered into s_out.
//   Ports:
//     clk          : clock, rising edge
//     rst          : asynchronous reset, active low
//     s_in         : round input state (byte 0 at [127:120], column-major)
//     round_key    : round key, same byte order
//     s_out        : registered round result
//     enc_en       : 1 = forward round, 0 = inverse round
//     final_rnd_en : 1 = skip (Inv)MixColumns
// ---------------------------------------------------------------------------
module encrypt_round
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s_in,
  input  logic [127:0] round_key,
  output logic [127:0] s_out,
  input  logic         enc_en,
  input  logic         final_rnd_en
);

  typedef struct packed {
    logic valid;  // stage 1 holds data sampled since reset release
    logic enc;
    logic fin;
  } ctrl_t;

  logic [127:0] shifted;
  logic [127:0] sub_q;
  logic [127:0] key_q;
  ctrl_t        ctrl_q;
  logic [127:0] inv_pre;
  logic [127:0] s_out_d;
  logic [127:0] s_out_q;

  // SubBytes is bytewise, so the row shift commutes with it; doing it on the
  // input lets forward and inverse share the same substitution stage.
  assign shifted = enc_en ? shift_rows(s_in) : inv_shift_rows(s_in);

  for (genvar c = 0; c < 4; c++) begin : g_sub
    substitute4 u_sub (
      .clk    (clk),
      .in     (shifted[127-32*c -: 32]),
      .out    (sub_q[127-32*c -: 32]),
      .enc_en (enc_en)
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q  <= '0;
      ctrl_q <= '0;
    end else begin
      key_q  <= round_key;
      ctrl_q <= '{valid: 1'b1, enc: enc_en, fin: final_rnd_en};
    end
  end

  assign inv_pre = sub_q ^ key_q;

  // NOTE: the output is defaulted first so no path through the block can
  // leave it unassigned and infer a latch.
  always_comb begin
    s_out_d = '0;
    // Gate with valid so the unreset S-box registers never reach s_out
    // during the first edge after reset release.
    if (ctrl_q.valid) begin
      if (ctrl_q.enc) s_out_d = (ctrl_q.fin ? sub_q : mix_columns(sub_q)) ^ key_q;
      else            s_out_d = ctrl_q.fin ? inv_pre : inv_mix_columns(inv_pre);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s_out_q <= '0;
    else      s_out_q <= s_out_d;
  end

  assign s_out = s_out_q;

endmodule

// File: tb/tb_encrypt_round.sv
// ---------------------------------------------------------------------------
// tb_encrypt_round
//   Directed vectors for encrypt_round and its substitute4 sub-block.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_encrypt_round;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_in;
  logic [127:0] round_key;
  logic [127:0] s_out;
  logic         enc_en;
  logic         final_rnd_en;

  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic         sub_enc;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] v_in  [6];
  logic [127:0] v_key [6];
  logic [127:0] v_exp [6];
  logic         v_enc [6];
  logic         v_fin [6];

  always #5 clk = ~clk;

  encrypt_round dut (
    .clk          (clk),
    .rst          (rst),
    .s_in         (s_in),
    .round_key    (round_key),
    .s_out        (s_out),
    .enc_en       (enc_en),
    .final_rnd_en (final_rnd_en)
  );

  substitute4 u_sub4 (
    .clk    (clk),
    .in     (sub_in),
    .out    (sub_out),
    .enc_en (sub_enc)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input int i);
    s_in         = v_in[i];
    round_key    = v_key[i];
    enc_en       = v_enc[i];
    final_rnd_en = v_fin[i];
  endtask

  task automatic check_vec(input int j);
    check($sformatf("vec%0d", j), s_out, v_exp[j]);
  endtask

  initial begin
    // FIPS-197 C.3 round 1, forward non-final
    v_in[0] = 128'h00102030405060708090a0b0c0d0e0f0;
    v_key[0] = 128'h101112131415161718191a1b1c1d1e1f;
    v_exp[0] = 128'h4f63760643e0aa85efa7213201a4e705;
    v_enc[0] = 1'b1; v_fin[0] = 1'b0;
    // FIPS-197 C.3 round 14, forward final
    v_in[1] = 128'h627bceb9999d5aaac945ecf423f56da5;
    v_key[1] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    v_exp[1] = 128'h8ea2b7ca516745bfeafc49904b496089;
    v_enc[1] = 1'b1; v_fin[1] = 1'b1;
    // final-round round trip with zero key
    v_in[2] = 128'h00102030405060708090a0b0c0d0e0f0;
    v_key[2] = '0;
    v_exp[2] = 128'h6353e08c0960e104cd70b751bacad0e7;
    v_enc[2] = 1'b1; v_fin[2] = 1'b1;
    v_in[3] = 128'h6353e08c0960e104cd70b751bacad0e7;
    v_key[3] = '0;
    v_exp[3] = 128'h00102030405060708090a0b0c0d0e0f0;
    v_enc[3] = 1'b0; v_fin[3] = 1'b1;
    // zero state, zero key, non-final
    v_in[4] = '0; v_key[4] = '0;
    v_exp[4] = {16{8'h63}};
    v_enc[4] = 1'b1; v_fin[4] = 1'b0;
    v_in[5] = '0; v_key[5] = '0;
    v_exp[5] = {16{8'h52}};
    v_enc[5] = 1'b0; v_fin[5] = 1'b0;

    rst = 1'b0;
    s_in = '0; round_key = '0; enc_en = 1'b1; final_rnd_en = 1'b0;
    sub_in = '0; sub_enc = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_s_out", s_out, '0);

    // substitute4: one registered cycle per lookup
    sub_in = 32'h00000000; sub_enc = 1'b1;
    @(negedge clk);
    check("sub4_fwd_zero", {96'h0, sub_out}, {96'h0, 32'h63636363});
    sub_in = 32'h53000000; sub_enc = 1'b1;
    @(negedge clk);
    check("sub4_fwd_53", {96'h0, sub_out}, {96'h0, 32'hed636363});
    sub_in = 32'hed636363; sub_enc = 1'b0;
    @(negedge clk);
    check("sub4_inv_ed", {96'h0, sub_out}, {96'h0, 32'h53000000});

    // Release reset and stream all vectors back to back
    @(negedge clk);
    rst = 1'b1;
    apply(0);
    @(negedge clk);
    check("first_edge_zero", s_out, '0);
    apply(1);
    for (int i = 2; i < 8; i++) begin
      @(negedge clk);
      check_vec(i - 2);
      if (i < 6) apply(i);
    end

    // Mid-stream reset: in-flight data discarded, output cleared at once
    @(negedge clk); apply(0);
    @(negedge clk); apply(1);
    @(negedge clk); check_vec(0); apply(2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rst_async_clear", s_out, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", i), s_out, '0);
    end

    // Release and stream in a different order to show per-input latency
    @(negedge clk);
    rst = 1'b1;
    apply(5);
    @(negedge clk);
    check("release_first_edge_zero", s_out, '0);
    apply(4);
    @(negedge clk); check_vec(5); apply(3);
    @(negedge clk); check_vec(4); apply(2);
    @(negedge clk); check_vec(3); apply(1);
    @(negedge clk); check_vec(2); apply(0);
    @(negedge clk); check_vec(1);
    @(negedge clk); check_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
